// File: rtl/gauss_frame_sequencer.sv
// Frame gate in front of gauss_filter_1x5: admits one WIDTH x HEIGHT frame, regenerates tlast,
// forces a blanking gap between lines and watches the filter output for count / tlast alignment.
module gauss_frame_sequencer #(
  parameter int WIDTH         = 640,
  parameter int HEIGHT        = 512,
  parameter int DATA_WIDTH    = 8,
  parameter int LINE_GAP      = 100,
  parameter int DRAIN_TIMEOUT = 4096
) (
  input  logic                      clk,
  input  logic                      rst_i,
  input  logic                      start_i,
  input  logic                      abort_i,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      err_tlast_o,
  output logic                      err_olast_o,
  output logic                      err_timeout_o,
  output logic [$clog2(HEIGHT)-1:0] line_o,
  input  logic [DATA_WIDTH-1:0]     s_axis_tdata,
  input  logic                      s_axis_tvalid,
  input  logic                      s_axis_tlast,
  output logic                      s_axis_tready,
  output logic [DATA_WIDTH-1:0]     f_axis_tdata,
  output logic                      f_axis_tvalid,
  output logic                      f_axis_tlast,
  input  logic                      f_axis_tready,
  input  logic                      m_axis_tvalid,
  input  logic                      m_axis_tready,
  input  logic                      m_axis_tlast
);

  localparam int TOTAL = WIDTH * HEIGHT;
  localparam int CW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int RW    = $clog2(HEIGHT);
  localparam int OCW   = $clog2(TOTAL + 1);
  localparam int GW    = (LINE_GAP > 1) ? $clog2(LINE_GAP) : 1;
  localparam int TW    = $clog2(DRAIN_TIMEOUT);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LINE  = 3'd1;
  localparam logic [2:0] S_GAP   = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [CW-1:0]  COL_LAST = CW'(WIDTH - 1);
  localparam logic [RW-1:0]  ROW_LAST = RW'(HEIGHT - 1);
  localparam logic [OCW-1:0] OUT_FULL = OCW'(TOTAL);
  localparam logic [GW-1:0]  GAP_LAST = GW'(LINE_GAP - 1);
  localparam logic [TW-1:0]  SIL_LAST = TW'(DRAIN_TIMEOUT - 1);

  logic [2:0]     state_reg, state_next;
  logic [CW-1:0]  col_reg, ocol_reg;
  logic [RW-1:0]  row_reg;
  logic [OCW-1:0] out_cnt_reg, out_cnt_next;
  logic [GW-1:0]  gap_reg;
  logic [TW-1:0]  silent_reg;
  logic           err_tlast_reg, err_olast_reg, err_timeout_reg;
  logic           in_line, col_last, ocol_last, in_beat, out_beat, timeout_hit, start_ok;

  assign in_line       = (state_reg == S_LINE);
  assign col_last      = (col_reg == COL_LAST);
  assign ocol_last     = (ocol_reg == COL_LAST);
  assign f_axis_tdata  = s_axis_tdata;
  assign f_axis_tvalid = s_axis_tvalid && in_line;
  assign s_axis_tready = f_axis_tready && in_line;
  assign f_axis_tlast  = col_last && in_line;
  assign in_beat       = s_axis_tvalid && s_axis_tready;

  // The output tap is only meaningful while a frame is in flight.
  assign out_beat = m_axis_tvalid && m_axis_tready &&
                    (state_reg == S_LINE || state_reg == S_GAP || state_reg == S_DRAIN);
  assign out_cnt_next = (out_beat && out_cnt_reg != OUT_FULL) ? out_cnt_reg + 1'b1 : out_cnt_reg;
  assign timeout_hit  = (state_reg == S_DRAIN) && !out_beat && (silent_reg == SIL_LAST);
  assign start_ok     = (state_reg == S_IDLE) && start_i && !abort_i;

  always_comb begin
    state_next = state_reg;
    if (abort_i) begin
      state_next = S_IDLE;
    end else begin
      case (state_reg)
        S_IDLE:  if (start_i) state_next = S_LINE;
        S_LINE:  if (in_beat && col_last) state_next = (row_reg == ROW_LAST) ? S_DRAIN : S_GAP;
        S_GAP:   if (gap_reg == GAP_LAST) state_next = S_LINE;
        S_DRAIN: if (out_cnt_next == OUT_FULL || timeout_hit) state_next = S_DONE;
        S_DONE:  state_next = S_IDLE;
        default: state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      state_reg       <= S_IDLE;
      col_reg         <= '0;
      row_reg         <= '0;
      ocol_reg        <= '0;
      out_cnt_reg     <= '0;
      gap_reg         <= '0;
      silent_reg      <= '0;
      err_tlast_reg   <= 1'b0;
      err_olast_reg   <= 1'b0;
      err_timeout_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (in_beat) begin
        if (s_axis_tlast != col_last) err_tlast_reg <= 1'b1;
        if (col_last) begin
          col_reg <= '0;
          if (row_reg != ROW_LAST) row_reg <= row_reg + 1'b1;
        end else begin
          col_reg <= col_reg + 1'b1;
        end
      end
      if (out_beat) begin
        out_cnt_reg <= out_cnt_next;
        if (m_axis_tlast != ocol_last) err_olast_reg <= 1'b1;
        ocol_reg <= ocol_last ? '0 : ocol_reg + 1'b1;
      end
      gap_reg    <= (state_reg == S_GAP) ? gap_reg + 1'b1 : '0;
      silent_reg <= (state_reg == S_DRAIN && !out_beat) ? silent_reg + 1'b1 : '0;
      if (timeout_hit && !abort_i) err_timeout_reg <= 1'b1;
      if (start_ok) begin
        col_reg         <= '0;
        row_reg         <= '0;
        ocol_reg        <= '0;
        out_cnt_reg     <= '0;
        err_tlast_reg   <= 1'b0;
        err_olast_reg   <= 1'b0;
        err_timeout_reg <= 1'b0;
      end
    end
  end

  assign busy_o        = (state_reg != S_IDLE);
  assign done_o        = (state_reg == S_DONE);
  assign err_tlast_o   = err_tlast_reg;
  assign err_olast_o   = err_olast_reg;
  assign err_timeout_o = err_timeout_reg;
  assign line_o        = row_reg;

endmodule

// File: tb/tb_gauss_frame_sequencer.sv
// Bench for gauss_frame_sequencer: random pixel data and ready patterns, 2-cycle filter model,
// frame-level reference (beat/line/gap arithmetic) compared against the DUT each cycle.
`timescale 1ns/1ps
module tb_gauss_frame_sequencer;
  localparam int W = 8, H = 4, GAP = 3, DT = 16, DW = 8, TOTAL = W * H;

  logic          clk = 1'b0;
  logic          rst_i, start_i, abort_i;
  logic          busy_o, done_o, err_tlast_o, err_olast_o, err_timeout_o;
  logic [1:0]    line_o;
  logic [DW-1:0] s_axis_tdata, f_axis_tdata;
  logic          s_axis_tvalid, s_axis_tlast, s_axis_tready;
  logic          f_axis_tvalid, f_axis_tlast, f_axis_tready;
  logic          m_axis_tvalid, m_axis_tready, m_axis_tlast;

  int n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  gauss_frame_sequencer #(.WIDTH(W), .HEIGHT(H), .DATA_WIDTH(DW), .LINE_GAP(GAP), .DRAIN_TIMEOUT(DT)) dut (
    .clk(clk), .rst_i(rst_i), .start_i(start_i), .abort_i(abort_i),
    .busy_o(busy_o), .done_o(done_o), .err_tlast_o(err_tlast_o), .err_olast_o(err_olast_o),
    .err_timeout_o(err_timeout_o), .line_o(line_o),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast),
    .s_axis_tready(s_axis_tready),
    .f_axis_tdata(f_axis_tdata), .f_axis_tvalid(f_axis_tvalid), .f_axis_tlast(f_axis_tlast),
    .f_axis_tready(f_axis_tready),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast)
  );

  // Filter stand-in: accepted beats reappear two cycles later; can go silent or flip one tlast.
  logic p0v = 1'b0, p0l = 1'b0, p1v = 1'b0, p1l = 1'b0;
  int   m_sent = 0;
  int   drop_after = 1000;
  int   flip_idx = -1;
  logic model_clr = 1'b1;

  always @(posedge clk) begin
    if (model_clr) begin
      p0v <= 1'b0; p0l <= 1'b0; p1v <= 1'b0; p1l <= 1'b0; m_sent <= 0;
    end else begin
      p0v <= f_axis_tvalid && f_axis_tready;
      p0l <= f_axis_tlast;
      p1v <= p0v;
      p1l <= p0l;
      if (m_axis_tvalid && m_axis_tready) m_sent <= m_sent + 1;
    end
  end
  assign m_axis_tvalid = p1v && (m_sent < drop_after);
  assign m_axis_tlast  = p1l ^ (m_sent == flip_idx);
  assign m_axis_tready = 1'b1;

  typedef struct packed {
    int   in_beats;
    int   tlast_bad;
    int   data_bad;
    int   ready_bad;
    int   line_bad;
    int   done_cnt;
    int   out_beats;
    int   cyc_last_in;
    int   cyc_last_out;
    int   cyc_done;
    int   err_t_first;
    int   busy_after_abort;
    logic err_t;
    logic err_o;
    logic err_to;
  } obs_t;

  // Runs one frame and gathers observations against the frame-level model; compares nothing itself.
  task automatic run_frame(input int ready_mode, input int bad_beat, input int abort_at,
                           input bit poke, output obs_t o);
    int   beats = 0, gap_left = 0, cyc = 0, post = 0;
    bit   aborted = 1'b0;
    logic exp_ready;
    logic [1:0] exp_line;
    o = '0;
    o.err_t_first = -1; o.cyc_done = -1; o.busy_after_abort = -1;
    o.cyc_last_out = -1;
    @(negedge clk); model_clr = 1'b1;
    @(negedge clk); model_clr = 1'b0;
    start_i = 1'b1; s_axis_tvalid = 1'b1; s_axis_tlast = 1'b0; f_axis_tready = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    while (post < 6 && cyc < 400) begin
      case (ready_mode)
        0:       f_axis_tready = 1'b1;
        1:       f_axis_tready = (cyc % 2 == 0);
        default: f_axis_tready = 1'($urandom_range(0, 1));
      endcase
      abort_i       = (abort_at >= 0) && !aborted && (beats == abort_at);
      s_axis_tvalid = !aborted && !abort_i;
      s_axis_tdata  = DW'($urandom);
      s_axis_tlast  = ((beats % W) == W - 1) ^ (beats == bad_beat);
      start_i       = poke && busy_o && (cyc % 5 == 2);
      #1;
      if (aborted && o.busy_after_abort < 0) o.busy_after_abort = int'(busy_o);
      exp_ready = (!aborted && beats < TOTAL && gap_left == 0) ? f_axis_tready : 1'b0;
      if (s_axis_tready !== exp_ready) o.ready_bad++;
      exp_line = (beats < TOTAL) ? 2'(beats / W) : 2'(H - 1);
      if (!aborted && line_o !== exp_line) o.line_bad++;
      if (err_tlast_o && o.err_t_first < 0) o.err_t_first = beats;
      if (s_axis_tvalid && s_axis_tready) begin
        if (f_axis_tlast !== ((beats % W) == W - 1)) o.tlast_bad++;
        if (f_axis_tdata !== s_axis_tdata || f_axis_tvalid !== 1'b1) o.data_bad++;
        beats++;
        o.cyc_last_in = cyc;
        if (beats % W == 0 && beats < TOTAL) gap_left = GAP;
      end else if (gap_left > 0) begin
        gap_left--;
      end
      if (m_axis_tvalid && m_axis_tready) begin
        o.out_beats++;
        if (o.out_beats == TOTAL) o.cyc_last_out = cyc;
      end
      if (done_o) begin
        o.done_cnt++;
        if (o.cyc_done < 0) o.cyc_done = cyc;
      end
      if (abort_i) aborted = 1'b1;
      if (o.cyc_done >= 0 || aborted) post++;
      cyc++;
      @(negedge clk);
    end
    start_i = 1'b0; abort_i = 1'b0; s_axis_tvalid = 1'b0;
    o.in_beats = beats;
    o.err_t = err_tlast_o; o.err_o = err_olast_o; o.err_to = err_timeout_o;
    $display("frame: mode=%0d in=%0d out=%0d done=%0d cyc_done=%0d err=%b%b%b",
             ready_mode, beats, o.out_beats, o.done_cnt, o.cyc_done, o.err_t, o.err_o, o.err_to);
  endtask

  task automatic test_reset();
    rst_i = 1'b1; model_clr = 1'b1; start_i = 1'b0; abort_i = 1'b0;
    s_axis_tvalid = 1'b1; s_axis_tdata = 8'hA5; s_axis_tlast = 1'b0; f_axis_tready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({s_axis_tready, f_axis_tvalid, f_axis_tlast, busy_o, done_o, err_tlast_o, err_olast_o,
           err_timeout_o, line_o} !== 10'b0) begin
        n_bad++;
        $display("FAIL reset_outputs cycle %0d: got rdy=%b fv=%b fl=%b busy=%b done=%b err=%b%b%b line=%0d expected all 0",
                 i, s_axis_tready, f_axis_tvalid, f_axis_tlast, busy_o, done_o, err_tlast_o,
                 err_olast_o, err_timeout_o, line_o);
      end
    end
    rst_i = 1'b0; s_axis_tvalid = 1'b0; model_clr = 1'b0;
    $display("reset: 5 cycles checked");
  endtask

  task automatic test_abort_start_same();
    @(negedge clk); start_i = 1'b1; abort_i = 1'b1;
    @(negedge clk); start_i = 1'b0; abort_i = 1'b0;
    n_cmp++;
    if (busy_o !== 1'b0) begin n_bad++; $display("FAIL abort_wins_over_start: busy=%b expected 0", busy_o); end
    $display("abort+start same cycle: busy=%b", busy_o);
  endtask

  task automatic test_clean_frame();
    obs_t o;
    run_frame(0, -1, -1, 1'b0, o);
    n_cmp++; if (o.in_beats != TOTAL) begin n_bad++; $display("FAIL clean_in_beats: got %0d expected %0d", o.in_beats, TOTAL); end
    n_cmp++; if (o.tlast_bad != 0) begin n_bad++; $display("FAIL clean_f_tlast: %0d misplaced expected 0", o.tlast_bad); end
    n_cmp++; if (o.data_bad != 0) begin n_bad++; $display("FAIL clean_f_data: %0d bad expected 0", o.data_bad); end
    n_cmp++; if (o.ready_bad != 0) begin n_bad++; $display("FAIL clean_ready_gap: %0d bad cycles expected 0", o.ready_bad); end
    n_cmp++; if (o.line_bad != 0) begin n_bad++; $display("FAIL clean_line_o: %0d bad cycles expected 0", o.line_bad); end
    n_cmp++; if (o.done_cnt != 1) begin n_bad++; $display("FAIL clean_done_count: got %0d expected 1", o.done_cnt); end
    n_cmp++; if (o.cyc_done != o.cyc_last_out + 1) begin n_bad++; $display("FAIL clean_done_timing: got cycle %0d expected %0d", o.cyc_done, o.cyc_last_out + 1); end
    n_cmp++; if ({o.err_t, o.err_o, o.err_to} !== 3'b000) begin n_bad++; $display("FAIL clean_errors: got %b%b%b expected 000", o.err_t, o.err_o, o.err_to); end
  endtask

  task automatic test_tlast_error();
    obs_t o;
    run_frame(0, W + 5, -1, 1'b0, o);
    n_cmp++; if (o.err_t_first != W + 6) begin n_bad++; $display("FAIL tlast_err_onset: first seen at beat %0d expected %0d", o.err_t_first, W + 6); end
    n_cmp++; if (o.err_t !== 1'b1) begin n_bad++; $display("FAIL tlast_err_sticky: got %b expected 1", o.err_t); end
    n_cmp++; if (o.tlast_bad != 0) begin n_bad++; $display("FAIL tlast_err_f_tlast: %0d misplaced expected 0", o.tlast_bad); end
    n_cmp++; if (o.done_cnt != 1) begin n_bad++; $display("FAIL tlast_err_done: got %0d expected 1", o.done_cnt); end
  endtask

  task automatic test_timeout();
    obs_t o;
    drop_after = TOTAL - 2;
    run_frame(0, -1, -1, 1'b0, o);
    drop_after = 1000;
    n_cmp++; if (o.out_beats != TOTAL - 2) begin n_bad++; $display("FAIL timeout_out_beats: got %0d expected %0d", o.out_beats, TOTAL - 2); end
    n_cmp++; if (o.cyc_done != o.cyc_last_in + DT + 1) begin n_bad++; $display("FAIL timeout_done_timing: got cycle %0d expected %0d", o.cyc_done, o.cyc_last_in + DT + 1); end
    n_cmp++; if (o.err_to !== 1'b1 || o.done_cnt != 1) begin n_bad++; $display("FAIL timeout_flag: err=%b done=%0d expected 1/1", o.err_to, o.done_cnt); end
  endtask

  task automatic test_olast_error();
    obs_t o;
    flip_idx = 10;
    run_frame(0, -1, -1, 1'b0, o);
    flip_idx = -1;
    n_cmp++; if ({o.err_t, o.err_o, o.err_to} !== 3'b010) begin n_bad++; $display("FAIL olast_err: got %b%b%b expected 010", o.err_t, o.err_o, o.err_to); end
    n_cmp++; if (o.done_cnt != 1) begin n_bad++; $display("FAIL olast_done: got %0d expected 1", o.done_cnt); end
  endtask

  task automatic test_abort();
    obs_t o;
    run_frame(0, 3, 2 * W + 3, 1'b0, o);
    n_cmp++; if (o.busy_after_abort != 0) begin n_bad++; $display("FAIL abort_busy: got %0d expected 0", o.busy_after_abort); end
    n_cmp++; if (o.done_cnt != 0) begin n_bad++; $display("FAIL abort_no_done: got %0d expected 0", o.done_cnt); end
    n_cmp++; if (o.in_beats != 2 * W + 3 || o.err_t !== 1'b1) begin n_bad++; $display("FAIL abort_state: beats=%0d err_t=%b expected %0d/1", o.in_beats, o.err_t, 2 * W + 3); end
    run_frame(0, -1, -1, 1'b0, o);
    n_cmp++; if ({o.err_t, o.err_o, o.err_to} !== 3'b000 || o.done_cnt != 1 || o.in_beats != TOTAL) begin
      n_bad++; $display("FAIL after_abort_frame: err=%b%b%b done=%0d beats=%0d expected 000/1/%0d", o.err_t, o.err_o, o.err_to, o.done_cnt, o.in_beats, TOTAL);
    end
  endtask

  task automatic test_back_to_back();
    obs_t o;
    for (int m = 1; m <= 2; m++) begin
      run_frame(m, -1, -1, 1'b1, o);
      n_cmp++; if (o.in_beats != TOTAL || o.done_cnt != 1) begin n_bad++; $display("FAIL stall_mode%0d_frame: beats=%0d done=%0d expected %0d/1", m, o.in_beats, o.done_cnt, TOTAL); end
      n_cmp++; if (o.ready_bad != 0 || o.tlast_bad != 0 || o.line_bad != 0) begin n_bad++; $display("FAIL stall_mode%0d_model: ready=%0d tlast=%0d line=%0d bad expected 0", m, o.ready_bad, o.tlast_bad, o.line_bad); end
    end
  endtask

  task automatic test_reset_mid_frame();
    @(negedge clk); model_clr = 1'b1;
    @(negedge clk); model_clr = 1'b0;
    start_i = 1'b1; s_axis_tvalid = 1'b1; s_axis_tlast = 1'b1; f_axis_tready = 1'b1;
    @(negedge clk); start_i = 1'b0;
    repeat (10) @(negedge clk);
    n_cmp++; if (err_tlast_o !== 1'b1 || busy_o !== 1'b1) begin n_bad++; $display("FAIL midreset_setup: err_t=%b busy=%b expected 1/1", err_tlast_o, busy_o); end
    rst_i = 1'b1;
    @(negedge clk); rst_i = 1'b0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    n_cmp++; if ({busy_o, err_tlast_o, line_o, s_axis_tready} !== 5'b0) begin n_bad++; $display("FAIL midreset_clear: busy=%b err_t=%b line=%0d rdy=%b expected 0", busy_o, err_tlast_o, line_o, s_axis_tready); end
    $display("reset mid-frame: busy=%b line=%0d", busy_o, line_o);
  endtask

  initial begin
    test_reset();
    test_abort_start_same();
    test_clean_frame();
    test_tlast_error();
    test_timeout();
    test_olast_error();
    test_abort();
    test_back_to_back();
    test_reset_mid_frame();
    test_clean_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
